alu_share_arbiter: RTL and testbench

- Shares one combinational n_bit_alu_four datapath between two requesters using valid/ready handshakes and round-robin arbitration.
- Registers the granted operands, drives the ALU for one execute cycle, then holds a registered result until the consumer accepts it.
- Sits between the two issuing units and the ALU, and is the only block that drives the ALU's A, B and control inputs.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_share_arbiter_alu.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing arbiter:
// opcode map, legal-opcode count and FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_0000 = 4'b0000; // add
    localparam logic [3:0] OP_0001 = 4'b0001; // sub
    localparam logic [3:0] OP_0010 = 4'b0010; // and
    localparam logic [3:0] OP_0011 = 4'b0011; // or
    localparam logic [3:0] OP_0100 = 4'b0100; // xor
    localparam logic [3:0] OP_0101 = 4'b0101; // nor
    localparam logic [3:0] OP_0110 = 4'b0110; // slt
    localparam logic [3:0] OP_0111 = 4'b0111; // sltu
    localparam logic [3:0] OP_1000 = 4'b1000; // sll
    localparam logic [3:0] OP_1001 = 4'b1001; // srl
    localparam logic [3:0] OP_1010 = 4'b1010; // sra

    localparam int NUM_OPS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational N-bit ALU with 11 operations and a zero flag.
// Unlisted control codes produce a zero result.
module n_bit_alu_four
    import alu_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   control,
    output logic [N-1:0] ALU_Result,
    output logic         zero
);

    localparam int SHW = $clog2(N);

    logic [SHW-1:0] w_shamt;

    assign w_shamt = B[SHW-1:0];

    always_comb begin
        ALU_Result = '0;
        case (control)
            OP_0000: ALU_Result = A + B;
            OP_0001: ALU_Result = A - B;
            OP_0010: ALU_Result = A & B;
            OP_0011: ALU_Result = A | B;
            OP_0100: ALU_Result = A ^ B;
            OP_0101: ALU_Result = ~(A | B);
            OP_0110: ALU_Result = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
            OP_0111: ALU_Result = {{(N-1){1'b0}}, A < B};
            OP_1000: ALU_Result = A << w_shamt;
            OP_1001: ALU_Result = A >> w_shamt;
            OP_1010: ALU_Result = $signed(A) >>> w_shamt;
            default: ALU_Result = '0;
        endcase
    end

    assign zero = ~|ALU_Result;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters:
// capture operands, execute one cycle, hold result until accepted.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N       = 32,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = alu_ctrl_pkg::NUM_OPS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [N-1:0]    resp_result,
    output logic            resp_zero,
    output logic            resp_id,
    output logic            resp_err,
    output logic            busy
);

    state_t          r_state;
    state_t          w_next;
    logic            r_last_grant;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [OP_W-1:0] r_op;
    logic            r_id;
    logic [N-1:0]    r_result;
    logic            r_zero;
    logic            r_resp_id;
    logic            r_err;

    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_illegal;
    logic [3:0]      w_alu_ctrl;
    logic [N-1:0]    w_alu_result;
    logic            w_alu_zero;

    // Under contention the requester not served last time wins.
    assign w_idle = (r_state == IDLE);
    assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

    assign w_illegal  = (r_op >= OP_W'(NUM_OPS));
    assign w_alu_ctrl = w_illegal ? OP_0000 : r_op[3:0];

    n_bit_alu_four #(
        .N (N)
    ) u_alu (
        .A          (r_a),
        .B          (r_b),
        .control    (w_alu_ctrl),
        .ALU_Result (w_alu_result),
        .zero       (w_alu_zero)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_gnt0 || w_gnt1) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_resp_id    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a          <= w_gnt1 ? req1_a  : req0_a;
                        r_b          <= w_gnt1 ? req1_b  : req0_b;
                        r_op         <= w_gnt1 ? req1_op : req0_op;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                    end
                end
                EXEC: begin
                    r_result  <= w_illegal ? '0 : w_alu_result;
                    r_zero    <= !w_illegal && w_alu_zero;
                    r_resp_id <= r_id;
                    r_err     <= w_illegal;
                end
                RESP: begin
                    if (resp_ready) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp_valid  = (r_state == RESP);
    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign resp_id     = r_resp_id;
    assign resp_err    = r_err;
    assign busy        = !w_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter.
// Expected responses queued at handshake.
module tb_alu_share_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [N-1:0] req0_a = '0;
  logic [N-1:0] req0_b = '0;
  logic [3:0]   req0_op = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [N-1:0] req1_a = '0;
  logic [N-1:0] req1_b = '0;
  logic [3:0]   req1_op = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [N-1:0] resp_result;
  logic         resp_zero;
  logic         resp_id;
  logic         resp_err;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic tb_lg  = 1'b1;

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t sb[$];

  alu_share_arbiter #(
    .N(N), .OP_W(4), .NUM_OPS(11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_id     (resp_id),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic [3:0] op
  );
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return {31'd0, $signed(a) < $signed(b)};
      4'd7:  return {31'd0, a < b};
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $signed(a) >>> b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic exp_t mk(
    input logic id,
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic [3:0] op
  );
    exp_t e;
    e.id   = id;
    e.err  = (op >= 4'd11);
    e.res  = e.err ? '0 : model(a, b, op);
    e.zero = !e.err && (e.res == '0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic id,
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic [3:0] op,
    output bit ok
  );
    ok = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b;
      req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b;
      req0_op = op; req0_valid = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      sb.push_back(mk(id, a, b, op));
      tb_lg = id;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_checks++;
    if ({resp_valid, resp_result, resp_zero,
         resp_id, resp_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%0d z=%b id=%b e=%b busy=%b required all 0",
               resp_valid, resp_result, resp_zero,
               resp_id, resp_err, busy);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 00",
               {req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    tb_lg = 1'b1;
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b required 01",
               {req1_ready, req0_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    exp_t e;
    resp_ready = 1'b1;
    send(1'b0, 32'd15, 32'd12, 4'd0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_accept: got no req0_ready required accept");
    end
    n_checks++;
    if ({resp_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_exec: got valid=%b busy=%b required 0 1",
               resp_valid, busy);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got resp_valid=%b required 1",
               resp_valid);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== e) begin
        n_fail++;
        $display("FAIL single_resp: got id=%b r=%0d z=%b e=%b required id=%b r=%0d z=%b e=%b",
                 resp_id, resp_result, resp_zero, resp_err,
                 e.id, e.res, e.zero, e.err);
      end
    end
    tick();
    n_checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got valid=%b busy=%b required 0 0",
               resp_valid, busy);
    end
  endtask

  task automatic test_zero;
    bit ok;
    exp_t e;
    resp_ready = 1'b1;
    send(1'b1, 32'd230005, 32'd230005, 4'd1, ok);
    wait_resp(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL zero_timeout: got no resp_valid required response");
    end
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== e) begin
        n_fail++;
        $display("FAIL zero_resp: got id=%b r=%0d z=%b e=%b required id=%b r=%0d z=%b e=%b",
                 resp_id, resp_result, resp_zero, resp_err,
                 e.id, e.res, e.zero, e.err);
      end
    end
    tick();
  endtask

  task automatic test_contention;
    int n_g = 0;
    int n_r = 0;
    int last_c = -1;
    bit granted;
    logic gid;
    exp_t e;
    resp_ready = 1'b1;
    req0_a = 32'd100; req0_b = 32'd3;  req0_op = 4'd0;
    req1_a = 32'd50;  req1_b = 32'd60; req1_op = 4'd1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 40 && n_r < 4; c++) begin
      #1;
      granted = 1'b0;
      gid = 1'b0;
      if (resp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_r++;
        n_checks++;
        if ({resp_id, resp_result, resp_zero, resp_err} !== e) begin
          n_fail++;
          $display("FAIL contention_resp: got id=%b r=%0d z=%b e=%b required id=%b r=%0d z=%b e=%b",
                   resp_id, resp_result, resp_zero, resp_err,
                   e.id, e.res, e.zero, e.err);
        end
      end
      if (req0_valid && req1_valid) begin
        n_checks++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
          n_fail++;
          $display("FAIL contention_onehot: got ready=11 required at most one");
        end
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gid = req1_ready;
        granted = 1'b1;
        n_checks++;
        if (gid !== ~tb_lg) begin
          n_fail++;
          $display("FAIL contention_order: got grant %b required %b",
                   gid, ~tb_lg);
        end
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c != 3) begin
            n_fail++;
            $display("FAIL contention_interval: got %0d required 3",
                     c - last_c);
          end
        end
        last_c = c;
        sb.push_back(gid ? mk(1'b1, req1_a, req1_b, req1_op)
                         : mk(1'b0, req0_a, req0_b, req0_op));
        tb_lg = gid;
        n_g++;
      end
      @(posedge clk);
      #1;
      if (granted) begin
        if (n_g == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end else if (gid) begin
          req1_a = req1_a + 32'd7;
          req1_op = 4'd4;
        end else begin
          req0_a = req0_a + 32'd9;
          req0_op = 4'd8;
        end
      end
    end
    n_checks++;
    if (n_r != 4) begin
      n_fail++;
      $display("FAIL contention_count: got %0d responses required 4", n_r);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic gid;
    exp_t e;
    resp_ready = 1'b0;
    send(1'b0, 32'd7, 32'd9, 4'd2, ok);
    wait_resp(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: got no resp_valid required response");
    end
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if ({resp_id, resp_result, resp_zero, resp_err} !== e) begin
      n_fail++;
      $display("FAIL bp_resp: got id=%b r=%0d z=%b e=%b required id=%b r=%0d z=%b e=%b",
               resp_id, resp_result, resp_zero, resp_err,
               e.id, e.res, e.zero, e.err);
    end
    req0_a = 32'd1;    req0_b = 32'd2; req0_op = 4'd0;
    req1_a = 32'd1000; req1_b = 32'd1; req1_op = 4'd1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== e.res ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b r=%0d rdy=%b%b required v=1 r=%0d rdy=00",
                 resp_valid, resp_result, req1_ready, req0_ready, e.res);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_no_comb_path: got %b required 00",
               {req1_ready, req0_ready});
    end
    tick();
    gid = ~tb_lg;
    n_checks++;
    if ({req1_ready, req0_ready} !== (gid ? 2'b10 : 2'b01) ||
        resp_valid !== 1'b0 || resp_result !== e.res) begin
      n_fail++;
      $display("FAIL bp_next_accept: got rdy=%b v=%b r=%0d required rdy=%b v=0 r=%0d",
               {req1_ready, req0_ready}, resp_valid, resp_result,
               (gid ? 2'b10 : 2'b01), e.res);
    end
    sb.push_back(gid ? mk(1'b1, req1_a, req1_b, req1_op)
                     : mk(1'b0, req0_a, req0_b, req0_op));
    tb_lg = gid;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(ok);
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || {resp_id, resp_result, resp_zero, resp_err} !== e) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b id=%b r=%0d required id=%b r=%0d",
               resp_valid, resp_id, resp_result, e.id, e.res);
    end
    tick();
  endtask

  task automatic test_illegal;
    bit ok;
    exp_t e;
    resp_ready = 1'b1;
    send(1'b0, 32'd44241422, 32'd4324222, 4'b1011, ok);
    wait_resp(ok);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || {resp_id, resp_result, resp_zero, resp_err} !== e) begin
      n_fail++;
      $display("FAIL illegal_resp: got v=%b r=%0d z=%b e=%b required r=%0d z=%b e=%b",
               resp_valid, resp_result, resp_zero, resp_err,
               e.res, e.zero, e.err);
    end
    tick();
    n_checks++;
    if ({resp_valid, resp_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_err_clear: got v=%b e=%b required 0 0",
               resp_valid, resp_err);
    end
    send(1'b0, 32'd20, 32'd5, 4'd3, ok);
    wait_resp(ok);
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || {resp_id, resp_result, resp_zero, resp_err} !== e) begin
      n_fail++;
      $display("FAIL illegal_next_legal: got r=%0d e=%b required r=%0d e=%b",
               resp_result, resp_err, e.res, e.err);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bit ok;
    exp_t e;
    resp_ready = 1'b1;
    send(1'b1, 32'd5, 32'd6, 4'd0, ok);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_exec: got busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid, resp_result, resp_zero,
         resp_id, resp_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b r=%0d z=%b id=%b e=%b busy=%b required all 0",
               resp_valid, resp_result, resp_zero,
               resp_id, resp_err, busy);
    end
    sb.delete();
    tb_lg = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_resp: got resp_valid=%b required 0",
                 resp_valid);
      end
    end
    req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd7;
    req1_a = 32'd8; req1_b = 32'd2; req1_op = 4'd0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_grant: got %b required 01",
               {req1_ready, req0_ready});
    end
    sb.push_back(mk(1'b0, req0_a, req0_b, req0_op));
    tb_lg = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(ok);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || {resp_id, resp_result, resp_zero, resp_err} !== e) begin
      n_fail++;
      $display("FAIL rstmid_after: got v=%b id=%b r=%0d required id=%b r=%0d",
               resp_valid, resp_id, resp_result, e.id, e.res);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
